// File: rtl/hpdcache_sram_ctrl_pkg.sv
// Shared types and constants for the single-port SRAM request/response controller.
package hpdcache_sram_ctrl_pkg;

    // Array initialisation FSM states (used when HPDCACHE_SRAM_INIT_EN is defined)
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    // Depth of the read-response buffer
    localparam int unsigned RSP_FIFO_DEPTH = 2;

endpackage

// File: rtl/hpdcache_sram_rsp_fifo.sv
// Two-entry response FIFO holding SRAM read data that could not be handed
// downstream in the cycle it came out of the SRAM.
module hpdcache_sram_rsp_fifo
    import hpdcache_sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [DATA_SIZE-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [DATA_SIZE-1:0] head_o,
    output logic [1:0]           cnt_o
);

    logic [DATA_SIZE-1:0] mem [RSP_FIFO_DEPTH];
    logic                 wptr;
    logic                 rptr;
    logic [1:0]           cnt;

    // Storage and pointers; single-bit pointers wrap modulo 2 naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '{default: '0};
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else begin
            if (push_i) begin
                mem[wptr] <= push_data_i;
                wptr      <= ~wptr;
            end
            if (pop_i) begin
                rptr <= ~rptr;
            end
        end
    end

    // Occupancy; simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (push_i && !pop_i) begin
            cnt <= cnt + 2'd1;
        end else if (pop_i && !push_i) begin
            cnt <= cnt - 2'd1;
        end
    end

    assign head_o = mem[rptr];
    assign cnt_o  = cnt;

    // The upstream ready logic guarantees the buffer never overflows or underflows
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && cnt == 2'(RSP_FIFO_DEPTH)));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && cnt == 2'd0));

endmodule

// File: rtl/hpdcache_sram_1rw_ctrl.sv
// Request/response front-end for a 1RW SRAM with one-cycle read latency.
// Optional feature: define HPDCACHE_SRAM_INIT_EN to zero-fill the array after
// reset before accepting requests.
module hpdcache_sram_1rw_ctrl
    import hpdcache_sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [ADDR_SIZE-1:0] req_addr_i,
    input  logic [DATA_SIZE-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATA_SIZE-1:0] rsp_rdata_o,
    output logic                 sram_cs_o,
    output logic                 sram_we_o,
    output logic [ADDR_SIZE-1:0] sram_addr_o,
    output logic [DATA_SIZE-1:0] sram_wdata_o,
    input  logic [DATA_SIZE-1:0] sram_rdata_i,
    output logic                 init_done_o
);

    if (DEPTH < 1 || DEPTH > 2**ADDR_SIZE) begin : g_bad_depth
        $error("hpdcache_sram_1rw_ctrl: DEPTH out of range 1..2**ADDR_SIZE");
    end

    logic                 init_done;
    logic                 req_accept;
    logic                 rd_pending;
    logic [1:0]           fifo_cnt;
    logic [DATA_SIZE-1:0] fifo_head;
    logic                 fifo_push;
    logic                 fifo_pop;

`ifdef HPDCACHE_SRAM_INIT_EN
    init_state_e          state;
    init_state_e          state_n;
    logic [ADDR_SIZE-1:0] init_addr;
    logic [ADDR_SIZE-1:0] init_addr_n;

    // Init FSM state and fill-address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            init_addr <= '0;
        end else begin
            state     <= state_n;
            init_addr <= init_addr_n;
        end
    end

    // Init FSM next state: step through every address once, then stay READY
    always_comb begin
        state_n     = state;
        init_addr_n = init_addr;
        case (state)
            INIT: begin
                init_addr_n = init_addr + 1'b1;
                if (init_addr == ADDR_SIZE'(DEPTH - 1)) begin
                    state_n = READY;
                end
            end
            READY: ;
            default: state_n = INIT;
        endcase
    end

    assign init_done = (state == READY);
`else
    assign init_done = 1'b1;
`endif

    assign init_done_o = init_done;

    // At most two reads may be outstanding (one in the SRAM pipeline plus buffered)
    assign req_ready_o = init_done
                       & ((3'(fifo_cnt) + 3'(rd_pending)) < 3'(RSP_FIFO_DEPTH));
    assign req_accept  = req_valid_i & req_ready_o;

    // SRAM strobes: accepted request passes straight through; init overrides
    always_comb begin
        sram_cs_o    = req_accept;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_wdata_i;
`ifdef HPDCACHE_SRAM_INIT_EN
        if (state == INIT) begin
            sram_cs_o    = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = init_addr;
            sram_wdata_o = '0;
        end
`endif
    end

    // Marks the cycle in which SRAM read data is present on sram_rdata_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= req_accept & ~req_we_i;
        end
    end

    // Fresh read data bypasses the buffer only when it is empty and downstream is ready
    assign fifo_push = rd_pending & ~((fifo_cnt == 2'd0) & rsp_ready_i);
    assign fifo_pop  = (fifo_cnt != 2'd0) & rsp_ready_i;

    assign rsp_valid_o = (fifo_cnt != 2'd0) | rd_pending;
    assign rsp_rdata_o = (fifo_cnt != 2'd0) ? fifo_head : sram_rdata_i;

    hpdcache_sram_rsp_fifo #(
        .DATA_SIZE (DATA_SIZE)
    ) i_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (sram_rdata_i),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .cnt_o       (fifo_cnt)
    );

endmodule

// File: tb/tb_hpdcache_sram_1rw_ctrl.sv
// Self-checking bench for hpdcache_sram_1rw_ctrl (ADDR_SIZE=4, DATA_SIZE=8, DEPTH=16).
// Works with or without HPDCACHE_SRAM_INIT_EN defined.
module tb_hpdcache_sram_1rw_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned DP = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          sram_cs_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic [DW-1:0] sram_rdata_i;
    logic          init_done_o;

    hpdcache_sram_1rw_ctrl #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .DEPTH     (DP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .sram_cs_o    (sram_cs_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i),
        .init_done_o  (init_done_o)
    );

    always #5 clk = ~clk;

    // Behavioural 1RW SRAM with registered read data
    logic [DW-1:0] sram_mem [DP];
    always @(posedge clk) begin
        if (sram_cs_o) begin
            if (sram_we_o) sram_mem[sram_addr_o] <= sram_wdata_o;
            else           sram_rdata_i <= sram_mem[sram_addr_o];
        end
    end

    // Reference model: array contents as seen by requests, plus the ordered list
    // of read results accepted but not yet consumed downstream.
    logic [DW-1:0] shadow [DP];
    logic [DW-1:0] exp_q [$];
    bit            model_up;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, update it.
    task automatic step(input bit v, input bit we, input int unsigned a,
                        input int unsigned d, input bit rr, output bit acc);
        bit exp_ready;
        bit exp_valid;
        @(negedge clk);
        req_valid_i = v;
        req_we_i    = we;
        req_addr_i  = a[AW-1:0];
        req_wdata_i = d[DW-1:0];
        rsp_ready_i = rr;
        #1;
        exp_valid = exp_q.size() > 0;
        exp_ready = model_up && exp_q.size() < 2;
        chk("req_ready", {31'b0, req_ready_o}, {31'b0, exp_ready});
        chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, exp_valid});
        if (exp_valid) chk("rsp_rdata", {24'b0, rsp_rdata_o}, {24'b0, exp_q[0]});
        acc = v && exp_ready;
        chk("sram_cs", {31'b0, sram_cs_o}, {31'b0, acc});
        if (acc) begin
            chk("sram_we", {31'b0, sram_we_o}, {31'b0, we});
            chk("sram_addr", {28'b0, sram_addr_o}, a);
            if (we) chk("sram_wdata", {24'b0, sram_wdata_o}, d & 32'hFF);
        end
        if (rr && exp_valid) void'(exp_q.pop_front());
        if (acc) begin
            if (we) shadow[a] = d[DW-1:0];
            else    exp_q.push_back(shadow[a]);
        end
    endtask

    // Reset (possibly mid-traffic), then the post-release bring-up checks.
    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        exp_q.delete();
`ifdef HPDCACHE_SRAM_INIT_EN
        model_up = 1'b0;
        chk("rst_init_done", {31'b0, init_done_o}, 32'd0);
        chk("rst_cs", {31'b0, sram_cs_o}, 32'd1);
        chk("rst_addr", {28'b0, sram_addr_o}, 32'd0);
        for (int i = 0; i < int'(DP); i++) shadow[i] = '0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`ifdef HPDCACHE_SRAM_INIT_EN
        req_valid_i = 1'b1;
        for (int i = 0; i < int'(DP); i++) begin
            #1;
            chk("init_cs", {31'b0, sram_cs_o}, 32'd1);
            chk("init_we", {31'b0, sram_we_o}, 32'd1);
            chk("init_addr", {28'b0, sram_addr_o}, i);
            chk("init_wdata", {24'b0, sram_wdata_o}, 32'd0);
            chk("init_done_low", {31'b0, init_done_o}, 32'd0);
            chk("init_ready_low", {31'b0, req_ready_o}, 32'd0);
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        #1;
        chk("init_done_high", {31'b0, init_done_o}, 32'd1);
        chk("init_ready_high", {31'b0, req_ready_o}, 32'd1);
        model_up = 1'b1;
`else
        #1;
        chk("nodef_init_done", {31'b0, init_done_o}, 32'd1);
        chk("nodef_ready", {31'b0, req_ready_o}, 32'd1);
        chk("nodef_idle_cs", {31'b0, sram_cs_o}, 32'd0);
        model_up = 1'b1;
`endif
    endtask

    initial begin
        bit acc;
        int idx;
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b0;
        model_up    = 1'b0;
        for (int i = 0; i < int'(DP); i++) begin
            sram_mem[i] = '0;
            shadow[i]   = '0;
        end
        repeat (2) @(negedge clk);
        do_reset();

        // Write then read-back of the same address
        step(1, 1, 3, 'hA5, 1, acc);
        step(1, 0, 3, 0, 1, acc);
        step(0, 0, 0, 0, 1, acc);

        // Preload addresses 0..7 with their index, then stream 8 reads
        for (int i = 0; i < 8; i++) step(1, 1, i, i, 1, acc);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, i, 0, 1, acc);
            chk("b2b_accept", {31'b0, acc}, 32'd1);
        end
        step(0, 0, 0, 0, 1, acc);
        step(0, 0, 0, 0, 1, acc);

        // Backpressure: four reads offered, only two taken until downstream drains
        for (int i = 0; i < 4; i++) begin
            step(1, 0, i, 0, 0, acc);
            chk("bp_accept", {31'b0, acc}, (i < 2) ? 32'd1 : 32'd0);
        end
        idx = 2;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            step(1, 0, idx, 0, 1, acc);
            if (acc) idx++;
        end
        if (idx < 4) chk("bp_timeout", idx, 32'd4);
        repeat (4) step(0, 0, 0, 0, 1, acc);

        // Reset while two responses are buffered; nothing stale afterwards
        step(1, 0, 5, 0, 0, acc);
        step(1, 0, 6, 0, 0, acc);
        step(0, 0, 0, 0, 0, acc);
        do_reset();
        repeat (3) step(0, 0, 0, 0, 1, acc);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 $urandom_range(0, DP - 1), $urandom_range(0, 255),
                 ($urandom_range(0, 9) < 7), acc);
        end
        repeat (4) step(0, 0, 0, 0, 1, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
